// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: streams program words into IMEM, holds the core in reset, then releases it at START_PC.
// Optional trailing-checksum verification is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int START_PC = 600,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             core_rst,
  output logic [31:0]      pc_start,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_RELEASE,
    S_RUN
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [31:0]      r_ptr;
  logic [CNT_W-1:0] r_remain;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic             r_done;
  logic             r_err;
  logic             w_xfer;
  logic             w_last;
  logic             w_reject;
  logic [32:0]      w_end;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]      r_sum;
`endif

  // One-past-the-end address in 33 bits; landing exactly on 2^32 is still legal.
  assign w_end    = {1'b0, base_addr} + (33'(word_count) << 2);
  assign w_reject = (word_count == '0) || (base_addr[1:0] != 2'b00) ||
                    (w_end > 33'h1_0000_0000);
  assign w_xfer   = in_valid && in_ready;
  assign w_last   = (r_remain == CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start && !w_reject) w_next = S_LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_LOAD:    if (w_xfer && w_last) w_next = S_CSUM;
      S_CSUM:    if (w_xfer) w_next = (in_data == r_sum) ? S_RELEASE : S_IDLE;
`else
      S_LOAD:    if (w_xfer && w_last) w_next = S_RELEASE;
`endif
      S_RELEASE: w_next = S_RUN;
      S_RUN:     w_next = S_RUN;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    core_rst = 1'b1;
    case (r_state)
      S_LOAD:    begin in_ready = 1'b1; busy = 1'b1; end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM:    begin in_ready = 1'b1; busy = 1'b1; end
`endif
      S_RELEASE: busy = 1'b1;
      S_RUN:     core_rst = 1'b0;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_remain    <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      r_err    <= 1'b0;
      r_done   <= (r_state == S_RELEASE);
      if (r_state == S_IDLE && start) begin
        if (w_reject) begin
          r_err <= 1'b1;
        end else begin
          r_ptr    <= base_addr;
          r_remain <= word_count;
`ifdef IMEM_LOADER_CHECKSUM_EN
          r_sum    <= '0;
`endif
        end
      end
      if (r_state == S_LOAD && w_xfer) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_ptr;
        r_mem_wdata <= in_data;
        r_ptr       <= r_ptr + 32'd4;
        r_remain    <= r_remain - CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        r_sum       <= r_sum + in_data;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      // The trailer is only compared, never written to memory.
      if (r_state == S_CSUM && w_xfer && in_data != r_sum) r_err <= 1'b1;
`endif
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign done      = r_done;
  assign err       = r_err;
  assign pc_start  = 32'(START_PC);

endmodule
